// File: rtl/seu_inject_sequencer.sv
// Soft-error injection campaign controller: issues strided SEM injections one at a time,
// handshakes with SEM status, and classifies each outcome into saturating counters.
module seu_inject_sequencer #(
  parameter int ADDR_W      = 40,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 1333333
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [CNT_W-1:0]  i_num_inject,
  input  logic [31:0]       i_interval,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W-1:0] i_addr_stride,
  input  logic [2:0]        i_strobe_sel,
  input  logic              i_status_observation,
  input  logic              i_status_correction,
  input  logic              i_status_uncorrectable,
  input  logic              i_error_det,
  output logic              o_inject_start,
  output logic [2:0]        o_inject_strobe_sel,
  output logic [ADDR_W-1:0] o_inject_addr,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_aborted,
  output logic [CNT_W-1:0]  o_inject_count,
  output logic [CNT_W-1:0]  o_corr_count,
  output logic [CNT_W-1:0]  o_uncorr_count,
  output logic [CNT_W-1:0]  o_timeout_count,
  output logic [CNT_W-1:0]  o_detect_count
);

  typedef enum logic [2:0] {
    IDLE, WAIT_READY, INJECT, WAIT_RESULT, RECOVER, GAP, FINISH
  } state_t;

  localparam logic [31:0]      TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  state_t            state_q, state_d;
  logic [31:0]       timer_q, timer_d;
  logic [31:0]       interval_q, interval_d;
  logic [CNT_W-1:0]  remain_q, remain_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        strobe_q, strobe_d;
  logic              inject_start_q, inject_start_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;
  logic [CNT_W-1:0]  inj_cnt_q, inj_cnt_d;
  logic [CNT_W-1:0]  corr_cnt_q, corr_cnt_d;
  logic [CNT_W-1:0]  uncorr_cnt_q, uncorr_cnt_d;
  logic [CNT_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [CNT_W-1:0]  det_cnt_q, det_cnt_d;
  logic              det_flag_q, det_flag_d;
  logic              tmo_flag_q, tmo_flag_d;
  logic              err_prev_q, err_prev_d;

  logic timer_expired, gap_last, err_rise, active;

  assign timer_expired = (timer_q == TIMEOUT_LAST);
  assign gap_last      = (timer_q == interval_q - 32'd1);
  assign err_rise      = i_error_det & ~err_prev_q;
  assign active        = (state_q != IDLE) && (state_q != FINISH);

  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    interval_d     = interval_q;
    remain_d       = remain_q;
    stride_d       = stride_q;
    addr_d         = addr_q;
    strobe_d       = strobe_q;
    inject_start_d = 1'b0;
    aborted_d      = aborted_q;
    inj_cnt_d      = inj_cnt_q;
    corr_cnt_d     = corr_cnt_q;
    uncorr_cnt_d   = uncorr_cnt_q;
    tmo_cnt_d      = tmo_cnt_q;
    det_cnt_d      = det_cnt_q;
    det_flag_d     = det_flag_q;
    tmo_flag_d     = tmo_flag_q;
    err_prev_d     = i_error_det;

    if (active && i_abort) begin
      state_d   = FINISH;
      aborted_d = 1'b1;
    end else begin
      if ((state_q == WAIT_RESULT || state_q == RECOVER) && err_rise && !det_flag_q) begin
        det_cnt_d  = sat_inc(det_cnt_q);
        det_flag_d = 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (i_start) begin
            interval_d   = i_interval;
            remain_d     = i_num_inject;
            stride_d     = i_addr_stride;
            addr_d       = i_base_addr;
            strobe_d     = i_strobe_sel;
            aborted_d    = 1'b0;
            inj_cnt_d    = '0;
            corr_cnt_d   = '0;
            uncorr_cnt_d = '0;
            tmo_cnt_d    = '0;
            det_cnt_d    = '0;
            state_d      = (i_num_inject == '0) ? FINISH : WAIT_READY;
          end
        end
        // The pulse and its count are registered together so the count is visible with the pulse.
        WAIT_READY: begin
          if (i_status_observation) begin
            state_d        = INJECT;
            inject_start_d = 1'b1;
            inj_cnt_d      = sat_inc(inj_cnt_q);
            remain_d       = remain_q - CNT_ONE;
          end
        end
        INJECT: begin
          timer_d    = '0;
          det_flag_d = 1'b0;
          tmo_flag_d = 1'b0;
          state_d    = WAIT_RESULT;
        end
        WAIT_RESULT: begin
          if (i_status_uncorrectable) begin
            uncorr_cnt_d = sat_inc(uncorr_cnt_q);
            aborted_d    = 1'b1;
            state_d      = FINISH;
          end else if (i_status_correction) begin
            corr_cnt_d = sat_inc(corr_cnt_q);
            timer_d    = '0;
            state_d    = RECOVER;
          end else if (timer_expired) begin
            tmo_cnt_d  = sat_inc(tmo_cnt_q);
            tmo_flag_d = 1'b1;
            timer_d    = '0;
            state_d    = RECOVER;
          end else begin
            timer_d = timer_q + 32'd1;
          end
        end
        // Recovery expiry only counts if this injection has not already timed out.
        RECOVER: begin
          if ((i_status_observation && !i_status_correction) || timer_expired) begin
            if (timer_expired && !tmo_flag_q) begin
              tmo_cnt_d  = sat_inc(tmo_cnt_q);
              tmo_flag_d = 1'b1;
            end
            addr_d  = addr_q + stride_q;
            timer_d = '0;
            if (interval_q != 32'd0)    state_d = GAP;
            else if (remain_q != '0)    state_d = WAIT_READY;
            else                        state_d = FINISH;
          end else begin
            timer_d = timer_q + 32'd1;
          end
        end
        GAP: begin
          if (gap_last) begin
            timer_d = '0;
            state_d = (remain_q != '0) ? WAIT_READY : FINISH;
          end else begin
            timer_d = timer_q + 32'd1;
          end
        end
        FINISH:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    // Busy covers the FINISH cycle; done follows it, so busy falls as done rises.
    busy_d = (state_d != IDLE);
    done_d = (state_q == FINISH);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q        <= IDLE;
      timer_q        <= '0;
      interval_q     <= '0;
      remain_q       <= '0;
      stride_q       <= '0;
      addr_q         <= '0;
      strobe_q       <= '0;
      inject_start_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      aborted_q      <= 1'b0;
      inj_cnt_q      <= '0;
      corr_cnt_q     <= '0;
      uncorr_cnt_q   <= '0;
      tmo_cnt_q      <= '0;
      det_cnt_q      <= '0;
      det_flag_q     <= 1'b0;
      tmo_flag_q     <= 1'b0;
      err_prev_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      interval_q     <= interval_d;
      remain_q       <= remain_d;
      stride_q       <= stride_d;
      addr_q         <= addr_d;
      strobe_q       <= strobe_d;
      inject_start_q <= inject_start_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      aborted_q      <= aborted_d;
      inj_cnt_q      <= inj_cnt_d;
      corr_cnt_q     <= corr_cnt_d;
      uncorr_cnt_q   <= uncorr_cnt_d;
      tmo_cnt_q      <= tmo_cnt_d;
      det_cnt_q      <= det_cnt_d;
      det_flag_q     <= det_flag_d;
      tmo_flag_q     <= tmo_flag_d;
      err_prev_q     <= err_prev_d;
    end
  end

  assign o_inject_start      = inject_start_q;
  assign o_inject_strobe_sel = strobe_q;
  assign o_inject_addr       = addr_q;
  assign o_busy              = busy_q;
  assign o_done              = done_q;
  assign o_aborted           = aborted_q;
  assign o_inject_count      = inj_cnt_q;
  assign o_corr_count        = corr_cnt_q;
  assign o_uncorr_count      = uncorr_cnt_q;
  assign o_timeout_count     = tmo_cnt_q;
  assign o_detect_count      = det_cnt_q;

endmodule

// File: doc/seu_inject_sequencer.md
# seu_inject_sequencer

Campaign controller for the SEM-based soft-error injection path. It issues a programmed number of injections, one at a time, into the configuration-memory injection interface. Each injection uses a strided address, and the block enforces a handshake with the SEM status outputs plus an inter-injection gap. It classifies each injection's outcome (corrected / uncorrectable / timeout / detected by the soft-error hub) into saturating counters that slow control reads back. It sits between the RBCP register block and the Monitor injection inputs, and replaces direct register-driven injection.

## Interface
- ADDR_W, 40, injection address width
- CNT_W, 16, width of count/statistics registers
- TIMEOUT_CYC, 1333333, per-injection result/recovery timeout in i_clk cycles (10 ms at 133 MHz)
- i_clk  in  1  system clock (clk133m domain)
- i_rst_n  in  1  reset, synchronous, active-low
- i_start  in  1  campaign start pulse; ignored while o_busy
- i_abort  in  1  abort campaign; level, sampled every cycle
- i_num_inject  in  CNT_W  injections in campaign; latched on start
- i_interval  in  32  gap cycles after each injection recovers; latched on start
- i_base_addr  in  ADDR_W  first injection address; latched on start
- i_addr_stride  in  ADDR_W  added to address after each injection; latched on start
- i_strobe_sel  in  3  strobe select; latched on start
- i_status_observation  in  1  SEM in observation (ready) state
- i_status_correction  in  1  SEM reports correction
- i_status_uncorrectable  in  1  SEM reports uncorrectable error
- i_error_det  in  1  OR of soft-error hub error flags
- o_inject_start  out  1  one-cycle injection pulse
- o_inject_strobe_sel  out  3  strobe select to SEM
- o_inject_addr  out  ADDR_W  injection address to SEM
- o_busy  out  1  campaign in progress
- o_done  out  1  one-cycle pulse at campaign end
- o_aborted  out  1  last campaign ended by abort or uncorrectable; held until next start
- o_inject_count / o_corr_count / o_uncorr_count / o_timeout_count / o_detect_count  out  CNT_W each  statistics

## Operation
- All inputs are synchronous to i_clk. CDC is done outside this block.
- States: IDLE, WAIT_READY, INJECT, WAIT_RESULT, RECOVER, GAP, FINISH.
- IDLE: on i_start, latch config. Clear all five counters and o_aborted. Load o_inject_addr = i_base_addr. Go to FINISH if i_num_inject == 0, else WAIT_READY.
- WAIT_READY: when i_status_observation = 1, go to INJECT. There is no timeout in this state.
- INJECT: o_inject_start = 1 for this single cycle. Increment o_inject_count. Clear the timer. Go to WAIT_RESULT.
- WAIT_RESULT:
  - i_status_uncorrectable = 1 has priority: increment o_uncorr_count, set o_aborted, go to FINISH.
  - Otherwise i_status_correction = 1: increment o_corr_count, clear the timer, go to RECOVER.
  - Otherwise, timer reaching TIMEOUT_CYC-1: increment o_timeout_count, go to RECOVER.
- RECOVER: when i_status_observation = 1 and i_status_correction = 0:
  - advance o_inject_addr += stride, modulo 2^ADDR_W;
  - go to GAP if i_interval != 0;
  - otherwise go to WAIT_READY if injections remain, else FINISH.
  - A timer expiry in RECOVER increments o_timeout_count (at most once per injection) and takes the same exit.
- GAP: count i_interval cycles, then go to WAIT_READY if injections remain, else FINISH.
- FINISH: o_done = 1 for one cycle. Go to IDLE.
- Detection: a rising edge of i_error_det during WAIT_RESULT or RECOVER increments o_detect_count. This happens at most once per injection, tracked by a per-injection flag cleared in INJECT.
- Abort: i_abort = 1 in any non-IDLE, non-FINISH state goes to FINISH next cycle and sets o_aborted. Counters keep their values. An injection pulse already issued stays counted.
- All counters saturate at 2^CNT_W-1.
- o_inject_strobe_sel holds the latched value from start until the next start.

## Timing
- Reset values: o_inject_start = 0, o_busy = 0, o_done = 0, o_aborted = 0, o_inject_addr = 0, o_inject_strobe_sel = 0, all counters = 0, state = IDLE.
- All outputs are registered.
- i_start sampled at cycle 0 with observation already high: o_busy = 1 from cycle 1, and o_inject_start = 1 in cycle 2.
- o_inject_addr and o_inject_strobe_sel are stable at least 1 cycle before o_inject_start and through WAIT_RESULT.
- o_busy deasserts in the same cycle o_done is high.
- A new i_start is accepted in the cycle after o_done.
- num_inject = 0: o_done in cycle 2, o_busy high only in cycle 1.
- Timeout fires exactly TIMEOUT_CYC cycles after the INJECT cycle if no status change occurs.
- A reset asserted mid-campaign returns the block to reset values on the next edge. No o_done is produced.

## Test plan
- Basic campaign: num_inject = 3, stride = 0x10, base = 0x100, interval = 5, SEM model corrects 20 cycles after each pulse, hub flags once per injection -> 3 pulses at addresses 0x100/0x110/0x120; inject = corr = detect = 3; timeout = 0; one o_done; o_aborted = 0.
- Timeout: SEM model silent, TIMEOUT_CYC = 100, num_inject = 2 -> timeout = 2, corr = 0; second pulse only after observation is high and the gap has elapsed.
- Uncorrectable: num_inject = 5, SEM model asserts correction and uncorrectable in the same cycle on the 2nd injection -> uncorr = 1, corr = 1, inject = 2, o_aborted = 1, o_done one cycle after.
- Abort mid-GAP with interval = 1000 -> o_done next cycle, o_aborted = 1, counters preserved; i_start pulsed while busy is ignored.
- Boundaries: num_inject = 0 -> no pulse, done at cycle 2. Address wrap: base = 2^40-0x8, stride = 0x10 -> second address 0x8. CNT_W = 4 with 20 corrected injections -> counters read 15.
- Reset: assert i_rst_n = 0 during WAIT_RESULT -> all outputs zero next edge; the next campaign runs normally.
